ahb_slave_resp_mux: RTL and testbench
=====================================

// Module: ahb_slave_resp_mux
// PURPOSE
// - AHB-Lite data-phase response multiplexer. Sits downstream of the address decoder.
// - Registers the decoder's MUX_SEL/HSEL_NOMAP in the address phase.
// - Steers the selected slave's HRDATA/HREADYOUT/HRESP back to the Cortex-M0 master in the data phase.
// - Contains the default slave: two-cycle ERROR response for active transfers to unmapped addresses.
// PARAMETERS
// - NSLV       10            number of mapped slaves, index 0..NSLV-1 (max 15)
// - NOMAP_IDX  4'd15         MUX_SEL code the decoder drives for unmapped addresses
// - IDLE_RDATA 32'h0000_0000 HRDATA driven when no slave owns the data phase
// PORTS
// - HCLK           in   1        system clock
// - HRESET         in   1        synchronous reset, active-high
// - MUX_SEL        in   4        slave number from address decoder (address phase)
// - HSEL_NOMAP     in   1        unmapped-address flag from address decoder
// - HTRANS         in   2        master transfer type; bit 1 = NONSEQ/SEQ
// - HRDATA_ALL     in   32*NSLV  slave read data, slave k at [32k+31:32k]
// - HREADYOUT_ALL  in   NSLV     slave ready outputs, bit k = slave k
// - HRESP_ALL      in   NSLV     slave responses, bit k = slave k (1 = ERROR)
// - HRDATA         out  32       read data to master
// - HREADY         out  1        bus ready to master and all slaves
// - HRESP          out  1        response to master
// - ERR_COUNT      out  16       default-slave error count (see CONFIGURATION)
// BEHAVIOUR
// - Registers:
//   - sel_q[3:0]: reset NOMAP_IDX.
//   - err_st: IDLE/ERR1/ERR2, reset IDLE.
// - Sampling:
//   - Address phase is sampled only on rising HCLK with HREADY=1: sel_q <= MUX_SEL.
//   - If HSEL_NOMAP=1 and HTRANS[1]=1, err_st <= ERR1; else err_st <= IDLE.
//   - MUX_SEL in [NSLV..14] is treated exactly as HSEL_NOMAP=1.
//   - HREADY=0: sel_q and err_st hold, except ERR1 -> ERR2 unconditionally.
// - Data-phase outputs (combinational from registers and slave inputs):
//   - sel_q < NSLV: HRDATA = slice sel_q; HREADY = HREADYOUT_ALL[sel_q]; HRESP = HRESP_ALL[sel_q].
//   - Otherwise, err_st=IDLE: HRDATA = IDLE_RDATA, HREADY = 1, HRESP = 0 (zero-wait OKAY for IDLE/BUSY to unmapped space).
//   - Otherwise, err_st=ERR1: HREADY = 0, HRESP = 1, HRDATA = IDLE_RDATA.
//   - Otherwise, err_st=ERR2: HREADY = 1, HRESP = 1, HRDATA = IDLE_RDATA.
// - Latency: error response is exactly 2 data-phase cycles (ERR1 then ERR2). Mapped slaves add 0 cycles of mux latency.
// - Boundary conditions:
//   - Back-to-back unmapped: in ERR2 HREADY=1, so a new unmapped active transfer samples and goes ERR2 -> ERR1 directly, with no IDLE gap.
//   - In ERR2 the master may cancel by presenting HTRANS=IDLE: next state IDLE, HREADY=1.
//   - Slave wait states: sel_q is held while the selected slave drives HREADYOUT=0, for unbounded cycles.
// - Reset in any state, including mid-ERR1 or mid-wait-state: next cycle sel_q=NOMAP_IDX, err_st=IDLE. Outputs HREADY=1, HRESP=0, HRDATA=IDLE_RDATA, ERR_COUNT=0.
// CONFIGURATION
// - Macro AHBMUX_ERRCOUNT_EN, defined:
//   - 16-bit counter increments once per error response, on the ERR1 -> ERR2 edge.
//   - Saturates at 16'hFFFF.
//   - Reset to 0 by HRESET only.
//   - Driven on ERR_COUNT.
// - Macro not defined: no counter logic; ERR_COUNT tied to 16'h0000.
// TESTING
// 1. Reset: HRESET=1 for 2 cycles -> HREADY=1, HRESP=0, HRDATA=IDLE_RDATA, ERR_COUNT=0.
// 2. NONSEQ read, MUX_SEL=1, slave 1 HRDATA=32'hCAFE_0001, HREADYOUT=1 -> next cycle HRDATA=32'hCAFE_0001, HREADY=1, HRESP=0.
// 3. Slave 2 selected, HREADYOUT_ALL[2] low 3 cycles while MUX_SEL changes to 0 -> HREADY=0 for 3 cycles, sel_q stays 2, then HRDATA from slave 2.
// 4. NONSEQ with HSEL_NOMAP=1, MUX_SEL=15 -> cycle 1 HREADY=0/HRESP=1, cycle 2 HREADY=1/HRESP=1, then OKAY; ERR_COUNT=1 if EN.
// 5. Two consecutive unmapped NONSEQ transfers -> ERR1, ERR2, ERR1, ERR2 with no OKAY cycle between; ERR_COUNT=2 if EN.
// 6. IDLE transfer with MUX_SEL=15; then HRESET asserted during ERR1 of a later unmapped NONSEQ:
//    - IDLE transfer -> zero-wait OKAY.
//    - Reset during ERR1 -> HREADY=1, HRESP=0 the cycle after reset.

Source files
------------

// File: rtl/ahb_slave_resp_mux.sv
// ----------------------------------------------------------------------------
// ahb_slave_resp_mux
//
// AHB-Lite data-phase response multiplexer for a Cortex-M0 bus. It sits
// downstream of the address decoder. It captures the decoder's slave number
// and unmapped flag in the address phase. In the following data phase it
// steers the owning slave's HRDATA/HREADYOUT/HRESP back to the master. It also
// contains the default slave, which answers active transfers to unmapped
// space with the standard two-cycle ERROR response.
//
// Optional feature macro: AHBMUX_ERRCOUNT_EN
//   defined   : saturating 16-bit count of default-slave ERROR responses
//   undefined : no counter logic, ERR_COUNT tied to zero
//
// Parameters
//   NSLV        number of mapped slaves, indices 0..NSLV-1 (max 15)
//   NOMAP_IDX   MUX_SEL code the decoder drives for unmapped addresses
//   IDLE_RDATA  HRDATA value when no slave owns the data phase
//
// Ports
//   HCLK           in   system clock
//   HRESET         in   synchronous reset, active-high
//   MUX_SEL        in   [3:0]       slave number from decoder (address phase)
//   HSEL_NOMAP     in               unmapped-address flag from decoder
//   HTRANS         in   [1:0]       transfer type, bit 1 set = NONSEQ/SEQ
//   HRDATA_ALL     in   [32*NSLV]   slave read data, slave k at [32k+31:32k]
//   HREADYOUT_ALL  in   [NSLV]      slave ready outputs, bit k = slave k
//   HRESP_ALL      in   [NSLV]      slave responses, bit k = slave k
//   HRDATA         out  [31:0]      read data to master
//   HREADY         out              bus ready to master and all slaves
//   HRESP          out              response to master (1 = ERROR)
//   ERR_COUNT      out  [15:0]      default-slave error count
// ----------------------------------------------------------------------------
module ahb_slave_resp_mux #(
   parameter int          NSLV       = 10,
   parameter logic [3:0]  NOMAP_IDX  = 4'd15,
   parameter logic [31:0] IDLE_RDATA = 32'h0000_0000
) (
   input  logic                HCLK,
   input  logic                HRESET,
   input  logic [3:0]          MUX_SEL,
   input  logic                HSEL_NOMAP,
   input  logic [1:0]          HTRANS,
   input  logic [32*NSLV-1:0]  HRDATA_ALL,
   input  logic [NSLV-1:0]     HREADYOUT_ALL,
   input  logic [NSLV-1:0]     HRESP_ALL,
   output logic [31:0]         HRDATA,
   output logic                HREADY,
   output logic                HRESP,
   output logic [15:0]         ERR_COUNT
);

   // Default-slave response states
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ERR1 = 2'd1;
   localparam logic [1:0] ST_ERR2 = 2'd2;

   localparam logic [3:0] NSLV_L = 4'(NSLV);

   logic [3:0] sel_q;
   logic [1:0] err_st;
   logic       nomap_in;
   logic       sel_mapped;

   // Any slave number the decoder cannot actually own is handled exactly
   // like an explicit unmapped flag, so a decoder glitch can never select a
   // non-existent slave and hang the bus.
   assign nomap_in   = HSEL_NOMAP || (MUX_SEL >= NSLV_L);
   assign sel_mapped = (sel_q < NSLV_L);

   // Address-phase capture. New selection and error state are accepted only
   // when the bus is ready. While a wait state is in progress everything holds.
   // The exception is the default slave: its first ERROR cycle always advances
   // to the second, because the default slave drives that wait state itself.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         sel_q  <= NOMAP_IDX;
         err_st <= ST_IDLE;
      end else if (HREADY) begin
         sel_q  <= MUX_SEL;
         err_st <= (nomap_in && HTRANS[1]) ? ST_ERR1 : ST_IDLE;
      end else if (err_st == ST_ERR1) begin
         err_st <= ST_ERR2;
      end
   end

   // Data-phase steering. A mapped selection passes the slave straight
   // through with no added latency. Otherwise the default slave answers:
   // zero-wait OKAY for IDLE/BUSY, or the two-cycle ERROR sequence.
   always_comb begin
      HRDATA = IDLE_RDATA;
      HREADY = 1'b1;
      HRESP  = 1'b0;
      if (sel_mapped) begin
         for (int k = 0; k < NSLV; k++) begin
            if (sel_q == 4'(k)) begin
               HRDATA = HRDATA_ALL[32*k +: 32];
               HREADY = HREADYOUT_ALL[k];
               HRESP  = HRESP_ALL[k];
            end
         end
      end else begin
         case (err_st)
            ST_ERR1: begin
               HREADY = 1'b0;
               HRESP  = 1'b1;
            end
            ST_ERR2: begin
               HREADY = 1'b1;
               HRESP  = 1'b1;
            end
            default: begin
               HREADY = 1'b1;
               HRESP  = 1'b0;
            end
         endcase
      end
   end

`ifdef AHBMUX_ERRCOUNT_EN
   logic [15:0] err_count;

   // One count per ERROR response. The count is taken on the ERR1 -> ERR2
   // step so that a response cut short by reset is never counted. The
   // counter sticks at all-ones instead of wrapping.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         err_count <= 16'h0000;
      end else if (!HREADY && (err_st == ST_ERR1) && (err_count != 16'hFFFF)) begin
         err_count <= err_count + 16'd1;
      end
   end

   assign ERR_COUNT = err_count;
`else
   assign ERR_COUNT = 16'h0000;
`endif

endmodule

// File: tb/tb_ahb_slave_resp_mux.sv
// ----------------------------------------------------------------------------
// tb_ahb_slave_resp_mux
//
// Directed bench for ahb_slave_resp_mux. Each bus cycle starts on the falling
// clock edge. The bench drives the next address phase and the current slave
// responses there, and it queues the data-phase outputs it expects for that
// same cycle. After the outputs settle, it pops the queued entry and compares
// it against the DUT.
// ----------------------------------------------------------------------------
module tb_ahb_slave_resp_mux;

   localparam int NSLV = 10;

`ifdef AHBMUX_ERRCOUNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   localparam logic [1:0] T_IDLE   = 2'b00;
   localparam logic [1:0] T_BUSY   = 2'b01;
   localparam logic [1:0] T_NONSEQ = 2'b10;
   localparam logic [1:0] T_SEQ    = 2'b11;

   logic               HCLK;
   logic               HRESET;
   logic [3:0]         MUX_SEL;
   logic               HSEL_NOMAP;
   logic [1:0]         HTRANS;
   logic [32*NSLV-1:0] HRDATA_ALL;
   logic [NSLV-1:0]    HREADYOUT_ALL;
   logic [NSLV-1:0]    HRESP_ALL;
   logic [31:0]        HRDATA;
   logic               HREADY;
   logic               HRESP;
   logic [15:0]        ERR_COUNT;

   typedef struct {
      string       tag;
      logic [31:0] rdata;
      logic        ready;
      logic        resp;
      logic [15:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   ahb_slave_resp_mux #(
      .NSLV       (NSLV),
      .NOMAP_IDX  (4'd15),
      .IDLE_RDATA (32'h0000_0000)
   ) dut (
      .HCLK          (HCLK),
      .HRESET        (HRESET),
      .MUX_SEL       (MUX_SEL),
      .HSEL_NOMAP    (HSEL_NOMAP),
      .HTRANS        (HTRANS),
      .HRDATA_ALL    (HRDATA_ALL),
      .HREADYOUT_ALL (HREADYOUT_ALL),
      .HRESP_ALL     (HRESP_ALL),
      .HRDATA        (HRDATA),
      .HREADY        (HREADY),
      .HRESP         (HRESP),
      .ERR_COUNT     (ERR_COUNT)
   );

   // 10 ns clock
   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   // Expected counter value depends on whether the counter is built in
   function automatic logic [15:0] cnt_of(input int n);
      return CNT_EN ? 16'(n) : 16'h0000;
   endfunction

   // Drive one address phase and queue the outputs expected for this cycle
   task automatic applyStimulus(input string tag, input logic rst,
                                input logic [3:0] sel, input logic nomap,
                                input logic [1:0] trans,
                                input logic [31:0] e_rdata, input logic e_ready,
                                input logic e_resp, input int e_cnt);
      exp_t e;
      HRESET     = rst;
      MUX_SEL    = sel;
      HSEL_NOMAP = nomap;
      HTRANS     = trans;
      e.tag   = tag;
      e.rdata = e_rdata;
      e.ready = e_ready;
      e.resp  = e_resp;
      e.cnt   = cnt_of(e_cnt);
      exp_q.push_back(e);
   endtask

   // Pop the oldest expectation and compare all data-phase outputs
   task automatic checkOutput();
      exp_t e;
      total++;
      assert (exp_q.size() != 0) else begin
         bad++;
         $error("[TB] FAIL scoreboard empty got=0 exp=1");
      end
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         total++;
         assert (HRDATA === e.rdata) else begin
            bad++;
            $error("[TB] FAIL %s hrdata got=%h exp=%h", e.tag, HRDATA, e.rdata);
         end
         total++;
         assert (HREADY === e.ready) else begin
            bad++;
            $error("[TB] FAIL %s hready got=%b exp=%b", e.tag, HREADY, e.ready);
         end
         total++;
         assert (HRESP === e.resp) else begin
            bad++;
            $error("[TB] FAIL %s hresp got=%b exp=%b", e.tag, HRESP, e.resp);
         end
         total++;
         assert (ERR_COUNT === e.cnt) else begin
            bad++;
            $error("[TB] FAIL %s err_count got=%h exp=%h", e.tag, ERR_COUNT, e.cnt);
         end
      end
   endtask

   // One full bus cycle: drive, settle, check, then advance past the edge
   task automatic step(input string tag, input logic rst,
                       input logic [3:0] sel, input logic nomap,
                       input logic [1:0] trans,
                       input logic [31:0] e_rdata, input logic e_ready,
                       input logic e_resp, input int e_cnt);
      applyStimulus(tag, rst, sel, nomap, trans, e_rdata, e_ready, e_resp, e_cnt);
      #1;
      checkOutput();
      @(posedge HCLK);
      @(negedge HCLK);
   endtask

   initial begin
      for (int k = 0; k < NSLV; k++) begin
         HRDATA_ALL[32*k +: 32] = 32'hCAFE_0000 | 32'(k);
      end
      HREADYOUT_ALL = '1;
      HRESP_ALL     = '0;
      HRESP_ALL[5]  = 1'b1;
      HRESET        = 1'b1;
      MUX_SEL       = 4'd15;
      HSEL_NOMAP    = 1'b1;
      HTRANS        = T_IDLE;

      repeat (2) @(posedge HCLK);
      @(negedge HCLK);
      $display("[TB] reset released");

      // Reset state, and the address phase of a read from slave 1
      step("reset",      1'b0, 4'd1,  1'b0, T_NONSEQ, 32'h0000_0000, 1'b1, 1'b0, 0);
      // Data from slave 1; address phase of a read from slave 2
      step("slv1_read",  1'b0, 4'd2,  1'b0, T_NONSEQ, 32'hCAFE_0001, 1'b1, 1'b0, 0);

      // Slave 2 stalls for three cycles while the decoder moves on to slave 0
      HREADYOUT_ALL[2] = 1'b0;
      step("slv2_wait1", 1'b0, 4'd0,  1'b0, T_NONSEQ, 32'hCAFE_0002, 1'b0, 1'b0, 0);
      step("slv2_wait2", 1'b0, 4'd0,  1'b0, T_NONSEQ, 32'hCAFE_0002, 1'b0, 1'b0, 0);
      step("slv2_wait3", 1'b0, 4'd0,  1'b0, T_NONSEQ, 32'hCAFE_0002, 1'b0, 1'b0, 0);
      HREADYOUT_ALL[2] = 1'b1;
      step("slv2_done",  1'b0, 4'd0,  1'b0, T_NONSEQ, 32'hCAFE_0002, 1'b1, 1'b0, 0);
      // Slave 0 data phase; address phase to unmapped space
      step("slv0_read",  1'b0, 4'd15, 1'b1, T_NONSEQ, 32'hCAFE_0000, 1'b1, 1'b0, 0);

      // Single ERROR response, followed by an idle cycle
      step("err_a1",     1'b0, 4'd0,  1'b0, T_IDLE,   32'h0000_0000, 1'b0, 1'b1, 0);
      step("err_a2",     1'b0, 4'd0,  1'b0, T_IDLE,   32'h0000_0000, 1'b1, 1'b1, 1);
      step("okay_a",     1'b0, 4'd15, 1'b1, T_NONSEQ, 32'hCAFE_0000, 1'b1, 1'b0, 1);

      // Back-to-back unmapped transfers; the second one is a SEQ transfer
      step("b2b_e1a",    1'b0, 4'd15, 1'b1, T_NONSEQ, 32'h0000_0000, 1'b0, 1'b1, 1);
      step("b2b_e2a",    1'b0, 4'd15, 1'b1, T_SEQ,    32'h0000_0000, 1'b1, 1'b1, 2);
      step("b2b_e1b",    1'b0, 4'd15, 1'b1, T_SEQ,    32'h0000_0000, 1'b0, 1'b1, 2);
      // Master cancels in ERR2 by presenting IDLE
      step("b2b_e2b",    1'b0, 4'd15, 1'b1, T_IDLE,   32'h0000_0000, 1'b1, 1'b1, 3);
      step("cancel",     1'b0, 4'd15, 1'b1, T_BUSY,   32'h0000_0000, 1'b1, 1'b0, 3);

      // BUSY to unmapped space is a zero-wait OKAY. Next is an out-of-range
      // slave number without the unmapped flag.
      step("busy_okay",  1'b0, 4'd12, 1'b0, T_NONSEQ, 32'h0000_0000, 1'b1, 1'b0, 3);
      step("rng_e1",     1'b0, 4'd5,  1'b0, T_NONSEQ, 32'h0000_0000, 1'b0, 1'b1, 3);
      step("rng_e2",     1'b0, 4'd5,  1'b0, T_NONSEQ, 32'h0000_0000, 1'b1, 1'b1, 4);

      // Slave 5 returns its own ERROR, which passes straight through
      step("slv5_resp",  1'b0, 4'd15, 1'b1, T_NONSEQ, 32'hCAFE_0005, 1'b1, 1'b1, 4);

      // Reset asserted during ERR1 clears everything on the next edge
      step("rst_in_e1",  1'b1, 4'd15, 1'b1, T_NONSEQ, 32'h0000_0000, 1'b0, 1'b1, 4);
      step("after_rst",  1'b0, 4'd15, 1'b1, T_IDLE,   32'h0000_0000, 1'b1, 1'b0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
